// File: rtl/sdram_clk_rst_seq.sv
// -----------------------------------------------------------------------------
// sdram_clk_rst_seq
//   Clock/reset sequencer on the 74.25 MHz reference side of the SDRAM PLL.
//   It pulses the PLL reset and qualifies the PLL lock output. The SDRAM
//   controller reset is released only after lock has been stable for
//   LOCK_STABLE_CYC cycles and the SDRAM power-up wait has elapsed. A lock
//   loss or a software re-init request re-asserts the SDRAM reset and starts
//   a new PLL reset pulse. Everything runs on refclk, which never stops, so
//   sequencing continues even when the PLL output is dead.
//
// Ports
//   refclk        in   reference clock, sole clock of this block
//   rst           in   synchronous active-high reset
//   pll_locked    in   PLL lock, asynchronous to refclk
//   reinit_req    in   1-cycle pulse: restart the full PLL + SDRAM sequence
//   pll_rst       out  reset to the PLL (high = reset)
//   sdram_rst     out  reset to the SDRAM controller (high = held)
//   ready         out  high only while in RUN
//   lock_loss_cnt out  saturating count of lock losses seen in PWRUP/RUN
//   retry_cnt     out  saturating count of lock-wait timeouts
//   state_dbg     out  current FSM state encoding, for observation only
//
// Handshake: there is no valid/ready traffic here. reinit_req is a plain
//   single-cycle request sampled on every refclk edge; it needs no reply.
// -----------------------------------------------------------------------------
module sdram_clk_rst_seq #(
   parameter int PLL_RST_CYC      = 16,
   parameter int LOCK_TIMEOUT_CYC = 74250,
   parameter int LOCK_STABLE_CYC  = 1024,
   parameter int PWRUP_CYC        = 7425,
   parameter int CNT_W            = 17
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic       reinit_req,
   output logic       pll_rst,
   output logic       sdram_rst,
   output logic       ready,
   output logic [7:0] lock_loss_cnt,
   output logic [7:0] retry_cnt,
   output logic [2:0] state_dbg
);

   typedef enum logic [2:0] {
      S_PLL_RST   = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_PWRUP     = 3'd3,
      S_RUN       = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] PLL_RST_LOAD = CNT_W'(PLL_RST_CYC - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] STABLE_LOAD  = CNT_W'(LOCK_STABLE_CYC - 1);
   localparam logic [CNT_W-1:0] PWRUP_LOAD   = CNT_W'(PWRUP_CYC - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [1:0]       lock_sync;
   logic             lk;
   logic             lock_loss;
   logic             timeout;

   // Two-flop synchroniser; every decision below uses lk only.
   always_ff @(posedge refclk) begin
      if (rst) begin
         lock_sync <= 2'b00;
      end else begin
         lock_sync <= {lock_sync[0], pll_locked};
      end
   end

   assign lk = lock_sync[1];

   // Next-state / counter logic. The shared counter is reloaded on every
   // state entry and the state always exits at 0, so it never wraps.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = (cnt == '0) ? cnt : cnt - CNT_W'(1);
      lock_loss = 1'b0;
      timeout   = 1'b0;
      case (state)
         S_PLL_RST: begin
            if (cnt == '0) begin
               state_nxt = S_WAIT_LOCK;
               cnt_nxt   = TIMEOUT_LOAD;
            end
         end
         S_WAIT_LOCK: begin
            if (lk) begin
               state_nxt = S_STABLE;
               cnt_nxt   = STABLE_LOAD;
            end else if (cnt == '0) begin
               state_nxt = S_PLL_RST;
               cnt_nxt   = PLL_RST_LOAD;
               timeout   = 1'b1;
            end
         end
         S_STABLE: begin
            // A dropout here is not counted: the PLL never claimed stable lock.
            if (!lk) begin
               state_nxt = S_WAIT_LOCK;
               cnt_nxt   = TIMEOUT_LOAD;
            end else if (cnt == '0) begin
               state_nxt = S_PWRUP;
               cnt_nxt   = PWRUP_LOAD;
            end
         end
         S_PWRUP: begin
            if (!lk) begin
               state_nxt = S_PLL_RST;
               cnt_nxt   = PLL_RST_LOAD;
               lock_loss = 1'b1;
            end else if (cnt == '0) begin
               state_nxt = S_RUN;
               cnt_nxt   = '0;
            end
         end
         S_RUN: begin
            if (!lk) begin
               state_nxt = S_PLL_RST;
               cnt_nxt   = PLL_RST_LOAD;
               lock_loss = 1'b1;
            end
         end
         default: begin
            state_nxt = S_PLL_RST;
            cnt_nxt   = PLL_RST_LOAD;
         end
      endcase

      // Software re-init overrides the transition but a simultaneous lock
      // loss is still counted. A timeout in the same cycle is superseded.
      if (reinit_req) begin
         state_nxt = S_PLL_RST;
         cnt_nxt   = PLL_RST_LOAD;
         timeout   = 1'b0;
      end
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         state <= S_PLL_RST;
         cnt   <= PLL_RST_LOAD;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Outputs are registered from the next state so they change on the same
   // edge the state does.
   always_ff @(posedge refclk) begin
      if (rst) begin
         pll_rst   <= 1'b1;
         sdram_rst <= 1'b1;
         ready     <= 1'b0;
      end else begin
         pll_rst   <= (state_nxt == S_PLL_RST);
         sdram_rst <= (state_nxt != S_RUN);
         ready     <= (state_nxt == S_RUN);
      end
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         lock_loss_cnt <= 8'h00;
         retry_cnt     <= 8'h00;
      end else begin
         if (lock_loss && (lock_loss_cnt != 8'hFF)) begin
            lock_loss_cnt <= lock_loss_cnt + 8'd1;
         end
         if (timeout && (retry_cnt != 8'hFF)) begin
            retry_cnt <= retry_cnt + 8'd1;
         end
      end
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_sdram_clk_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_sdram_clk_rst_seq
//   Directed bench for sdram_clk_rst_seq with shortened timing parameters.
//   Expected output vectors {pll_rst, sdram_rst, ready, lock_loss_cnt,
//   retry_cnt} are queued when stimulus is applied and compared after the
//   stated number of refclk edges.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sdram_clk_rst_seq;

   logic       refclk;
   logic       rst;
   logic       pll_locked;
   logic       reinit_req;
   logic       pll_rst;
   logic       sdram_rst;
   logic       ready;
   logic [7:0] lock_loss_cnt;
   logic [7:0] retry_cnt;
   logic [2:0] state_dbg;

   logic [18:0] exp_q[$];
   string       tag_q[$];
   int          checks;
   int          failures;
   int          exp_llc;
   int          exp_rc;

   sdram_clk_rst_seq #(
      .PLL_RST_CYC      (4),
      .LOCK_TIMEOUT_CYC (32),
      .LOCK_STABLE_CYC  (8),
      .PWRUP_CYC        (16),
      .CNT_W            (17)
   ) dut (
      .refclk        (refclk),
      .rst           (rst),
      .pll_locked    (pll_locked),
      .reinit_req    (reinit_req),
      .pll_rst       (pll_rst),
      .sdram_rst     (sdram_rst),
      .ready         (ready),
      .lock_loss_cnt (lock_loss_cnt),
      .retry_cnt     (retry_cnt),
      .state_dbg     (state_dbg)
   );

   // Clock / watchdog
   initial begin
      refclk = 1'b0;
      forever #5 refclk = ~refclk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1);
   end

   // Driver / scoreboard tasks
   function automatic int sat8(input int v);
      return (v > 255) ? 255 : v;
   endfunction

   // Advance n edges; inputs are driven and outputs sampled 1 ns after the edge.
   task automatic step(input int n);
      repeat (n) @(posedge refclk);
      #1;
   endtask

   task automatic push_exp(input string tag, input logic pr, input logic sr, input logic rdy);
      logic [7:0] llc;
      logic [7:0] rc;
      llc = 8'(exp_llc);
      rc  = 8'(exp_rc);
      exp_q.push_back({pr, sr, rdy, llc, rc});
      tag_q.push_back(tag);
   endtask

   task automatic pop_check();
      logic [18:0] e;
      logic [18:0] o;
      string       t;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL scoreboard: observed=empty expected=entry");
         return;
      end
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      o = {pll_rst, sdram_rst, ready, lock_loss_cnt, retry_cnt};
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", t, o, e);
      end
   endtask

   task automatic expect_after(input string tag, input int n,
                               input logic pr, input logic sr, input logic rdy);
      push_exp(tag, pr, sr, rdy);
      step(n);
      pop_check();
   endtask

   // Directed sequence
   initial begin
      checks     = 0;
      failures   = 0;
      exp_llc    = 0;
      exp_rc     = 0;
      rst        = 1'b1;
      pll_locked = 1'b0;
      reinit_req = 1'b0;

      expect_after("reset", 2, 1'b1, 1'b1, 1'b0);
      rst = 1'b0;

      // No lock: 4-cycle pll_rst pulses separated by 32-cycle waits.
      expect_after("prst_hold", 3, 1'b1, 1'b1, 1'b0);
      expect_after("prst_fall", 1, 1'b0, 1'b1, 1'b0);
      expect_after("wait_hold", 31, 1'b0, 1'b1, 1'b0);
      exp_rc = 1;
      expect_after("timeout1", 1, 1'b1, 1'b1, 1'b0);
      expect_after("prst_hold2", 3, 1'b1, 1'b1, 1'b0);
      expect_after("prst_fall2", 1, 1'b0, 1'b1, 1'b0);
      exp_rc = 2;
      expect_after("timeout2", 32, 1'b1, 1'b1, 1'b0);
      expect_after("prst_fall3", 4, 1'b0, 1'b1, 1'b0);

      // Lock arrives 5 cycles after pll_rst fell; release 26 cycles later.
      step(4);
      pll_locked = 1'b1;
      expect_after("lock_lat_pre", 26, 1'b0, 1'b1, 1'b0);
      expect_after("lock_lat_rel", 1, 1'b0, 1'b0, 1'b1);

      // Lock loss in RUN: outputs react 3 edges after the input drops.
      pll_locked = 1'b0;
      expect_after("loss_pre", 2, 1'b0, 1'b0, 1'b1);
      exp_llc = 1;
      expect_after("loss_hit", 1, 1'b1, 1'b1, 1'b0);
      expect_after("loss_prst", 4, 1'b0, 1'b1, 1'b0);

      // Dropout during STABLE at count 4: back to WAIT_LOCK, window restarts.
      pll_locked = 1'b1;
      expect_after("stable_a", 5, 1'b0, 1'b1, 1'b0);
      pll_locked = 1'b0;
      expect_after("stable_drop", 3, 1'b0, 1'b1, 1'b0);
      pll_locked = 1'b1;
      for (int i = 0; i < 26; i++) begin
         expect_after("restable", 1, 1'b0, 1'b1, 1'b0);
      end
      expect_after("restable_rel", 1, 1'b0, 1'b0, 1'b1);

      // reinit_req coincident with the lk fall in RUN.
      pll_locked = 1'b0;
      expect_after("rq_pre", 2, 1'b0, 1'b0, 1'b1);
      reinit_req = 1'b1;
      exp_llc    = 2;
      expect_after("rq_hit", 1, 1'b1, 1'b1, 1'b0);
      reinit_req = 1'b0;
      expect_after("rq_prst", 3, 1'b1, 1'b1, 1'b0);
      expect_after("rq_fall", 1, 1'b0, 1'b1, 1'b0);

      // 300 timeouts saturate retry_cnt, then rst in the middle of PWRUP.
      exp_rc = sat8(exp_rc + 300);
      expect_after("retry_sat", 36 * 300, 1'b0, 1'b1, 1'b0);
      pll_locked = 1'b1;
      expect_after("pwrup", 15, 1'b0, 1'b1, 1'b0);
      rst     = 1'b1;
      exp_llc = 0;
      exp_rc  = 0;
      expect_after("mid_rst", 1, 1'b1, 1'b1, 1'b0);
      rst = 1'b0;

      // reinit_req during PLL_RST restarts the pulse.
      step(2);
      reinit_req = 1'b1;
      expect_after("reinit_ext", 1, 1'b1, 1'b1, 1'b0);
      reinit_req = 1'b0;
      expect_after("ext_hold", 3, 1'b1, 1'b1, 1'b0);
      expect_after("ext_fall", 1, 1'b0, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
